// File: rtl/mem_buf_pkg.sv
// mem_buf_pkg: shared transfer-state encoding and length helper for the mem_buf stream bridges
package mem_buf_pkg;
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DRAIN} xfer_state_t;
  function automatic logic [63:0] ceil_div_bits(input logic [63:0] nbytes, input int unsigned width);
    return ((nbytes << 3) + 64'(width) - 64'd1) / 64'(width);
  endfunction
endpackage

// File: rtl/axi_axis2bram_if.sv
// axi_axis2bram_if: AXI4-Stream data channel
interface axi_axis2bram_if #(parameter int DW = 512) ();
  logic          tvalid;
  logic          tready;
  logic [DW-1:0] tdata;
  logic          tlast;
  modport master (output tvalid, tdata, tlast, input tready);
  modport slave  (input tvalid, tdata, tlast, output tready);
endinterface

// File: rtl/axi_axis2bram.sv
// axi_axis2bram: AXI4-Stream slave that writes beat k to BRAM address k, checks tlast against the programmed length
module axi_axis2bram
  import mem_buf_pkg::*;
#(
  parameter int AXI_DATA_WIDTH      = 512,
  parameter int AXI_XFER_SIZE_WIDTH = 32,
  parameter int BRAM_ADDR_WIDTH     = 32,
  parameter int BRAM_DATA_WIDTH     = 512
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_as2b_start,
  output logic                           o_as2b_done,
  input  logic [AXI_XFER_SIZE_WIDTH-1:0] i_as2b_data_size_bytes,
  output logic                           o_as2b_err,
  axi_axis2bram_if.slave                 s_axis,
  output logic [BRAM_ADDR_WIDTH-1:0]     o_as2b_wraddr,
  output logic [BRAM_DATA_WIDTH-1:0]     o_as2b_wrdata,
  output logic                           o_as2b_wren
);
  localparam int CW = AXI_XFER_SIZE_WIDTH + 4;
  if (AXI_DATA_WIDTH != BRAM_DATA_WIDTH) begin : g_width_check
    $error("axi_axis2bram: AXI_DATA_WIDTH must equal BRAM_DATA_WIDTH");
  end
  xfer_state_t                state_q, state_d;
  logic [CW-1:0]              depth_q, depth_d, cnt_q, cnt_d, depth_in;
  logic                       tready_q, tready_d, err_q, err_d, wren_q, wren_d;
  logic [BRAM_ADDR_WIDTH-1:0] wraddr_q, wraddr_d;
  logic [BRAM_DATA_WIDTH-1:0] wrdata_q, wrdata_d;
  logic                       acc, last_beat;
  assign depth_in  = CW'(ceil_div_bits(64'(i_as2b_data_size_bytes), BRAM_DATA_WIDTH));
  assign acc       = s_axis.tvalid & tready_q;
  assign last_beat = cnt_q == depth_q - CW'(1);
  always_comb begin
    state_d  = state_q;
    depth_d  = depth_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    wren_d   = acc && state_q == S_BUSY;
    wraddr_d = wren_d ? BRAM_ADDR_WIDTH'(cnt_q) : wraddr_q;
    wrdata_d = wren_d ? s_axis.tdata : wrdata_q;
    case (state_q)
      S_IDLE: if (i_as2b_start && depth_in != '0) begin
        state_d = S_BUSY;
        depth_d = depth_in;
        cnt_d   = '0;
        err_d   = 1'b0;
      end
      S_BUSY: if (acc) begin
        cnt_d = cnt_q + CW'(1);
        if (last_beat) begin
          state_d = s_axis.tlast ? S_IDLE : S_DRAIN;
          err_d   = ~s_axis.tlast;
        end else if (s_axis.tlast) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
      end
      S_DRAIN: state_d = (acc && s_axis.tlast) ? S_IDLE : S_DRAIN;
      default: state_d = S_IDLE;
    endcase
    tready_d = state_d != S_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      depth_q  <= '0;
      cnt_q    <= '0;
      tready_q <= 1'b0;
      err_q    <= 1'b0;
      wren_q   <= 1'b0;
      wraddr_q <= '0;
      wrdata_q <= '0;
    end else begin
      state_q  <= state_d;
      depth_q  <= depth_d;
      cnt_q    <= cnt_d;
      tready_q <= tready_d;
      err_q    <= err_d;
      wren_q   <= wren_d;
      wraddr_q <= wraddr_d;
      wrdata_q <= wrdata_d;
    end
  end
  assign s_axis.tready = tready_q;
  assign o_as2b_done   = state_q == S_IDLE && !wren_q;
  assign o_as2b_err    = err_q;
  assign o_as2b_wren   = wren_q;
  assign o_as2b_wraddr = wraddr_q;
  assign o_as2b_wrdata = wrdata_q;
endmodule

// File: tb/tb_axi_axis2bram.sv
// tb_axi_axis2bram: randomized stream transfers checked against a packet-level model of the expected BRAM writes
module tb_axi_axis2bram;
  localparam int DW = 512, XW = 32, AW = 32;
  logic          clk = 0, rst_n = 0, start = 0;
  logic [XW-1:0] size = '0;
  logic          done, err, wren;
  logic [AW-1:0] wraddr;
  logic [DW-1:0] wrdata;
  int            vecs = 0, errs = 0, cyc = 0;
  logic [AW-1:0] got_a[$];
  logic [DW-1:0] got_d[$];
  int            got_c[$];
  logic [DW-1:0] sent[$];
  logic          exp_err = 0;
  always #5 clk = ~clk;
  axi_axis2bram_if #(.DW(DW)) axis ();
  axi_axis2bram dut (
    .clk(clk), .rst_n(rst_n), .i_as2b_start(start), .o_as2b_done(done),
    .i_as2b_data_size_bytes(size), .o_as2b_err(err), .s_axis(axis),
    .o_as2b_wraddr(wraddr), .o_as2b_wrdata(wrdata), .o_as2b_wren(wren)
  );
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (wren) begin
    got_a.push_back(wraddr);
    got_d.push_back(wrdata);
    got_c.push_back(cyc);
  end
  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction
  task automatic go(input int s);
    size = s;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    size = $urandom;
  endtask
  task automatic beats_out(input int n, input int last, input bit gap, input bit mid);
    bit ok;
    sent.delete();
    for (int b = 0; b < n; b++) begin
      axis.tvalid = 1;
      axis.tdata = rnd_data();
      axis.tlast = (b == last);
      sent.push_back(axis.tdata);
      if (mid && b == 1) begin
        start = 1;
        size = $urandom_range(1, 4096);
      end
      ok = 0;
      for (int t = 0; t < 16 && !ok; t++) begin
        @(negedge clk);
        ok = axis.tready;
        @(posedge clk); #1;
      end
      start = 0;
      if (!ok) chk("accept_timeout", 0, 1);
      axis.tvalid = 0;
      axis.tlast = 0;
      if (gap && b != n - 1) begin
        @(posedge clk); #1;
      end
    end
  endtask
  task automatic xfer(input int s, input int last, input bit gap, input bit mid);
    int depth, nw, n;
    depth = (s * 8 + DW - 1) / DW;
    got_a.delete(); got_d.delete(); got_c.delete();
    go(s);
    beats_out(last + 1, last, gap, mid);
    exp_err = (last != depth - 1);
    @(negedge clk);
    chk("done_lat1", done, (last <= depth - 1) ? 0 : 1);
    @(negedge clk);
    chk("done_lat2", done, 1);
    n = got_a.size();
    axis.tvalid = 1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_tready", axis.tready, 0);
    end
    axis.tvalid = 0;
    chk("idle_nowr", got_a.size(), n);
    nw = (last + 1 < depth) ? last + 1 : depth;
    chk("nwrites", got_a.size(), nw);
    for (int k = 0; k < nw && k < got_a.size(); k++) begin
      chk("wraddr", got_a[k], k);
      chk("wrdata", got_d[k], sent[k]);
      if (!gap && k > 0) chk("b2b", got_c[k] - got_c[k-1], 1);
    end
    chk("err", err, exp_err);
  endtask
  initial begin
    axis.tvalid = 0;
    axis.tdata = '0;
    axis.tlast = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("rst_tready", axis.tready, 0);
    chk("rst_wren", wren, 0);
    chk("rst_wraddr", wraddr, 0);
    chk("rst_wrdata", wrdata, 0);
    chk("rst_err", err, 0);
    chk("rst_done", done, 1);
    @(posedge clk); #1;
    xfer(256, 3, 0, 0);
    xfer(100, 1, 0, 0);
    xfer(256, 3, 1, 0);
    xfer(256, 1, 0, 0);
    xfer(256, 3, 0, 1);
    xfer(128, 4, 0, 0);
    go(256);
    beats_out(2, 99, 0, 0);
    rst_n = 0;
    #1;
    chk("arst_wren", wren, 0);
    chk("arst_tready", axis.tready, 0);
    chk("arst_done", done, 1);
    chk("arst_err", err, 0);
    exp_err = 0;
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    xfer(64, 0, 0, 0);
    go(0);
    repeat (2) begin
      @(negedge clk);
      chk("zero_tready", axis.tready, 0);
      chk("zero_done", done, 1);
      chk("zero_err", err, exp_err);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 25; i++) begin
      int s, d;
      s = $urandom_range(1, 512);
      d = (s * 8 + DW - 1) / DW;
      xfer(s, $urandom_range(0, d + 2), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
